// File: rtl/estufa_multizona_if.sv
// Bundle of the multizone greenhouse controller's sensor, command and actuator signals.
// Pure wiring. It adds no latency.
// No backpressure. Every signal is a level that is sampled on every clock edge.
// Ports (grouped):
//   enable, sensors, fault_clr : controller inputs
//   heater, cooler, fault, level_out : controller outputs
interface estufa_multizona_if #(
  parameter int NZONES  = 2,
  parameter int NLEVELS = 4
);
  localparam int LW = $clog2(NLEVELS + 1);

  logic                        enable;
  logic [NZONES*NLEVELS-1:0]   sensors;
  logic [NZONES-1:0]           fault_clr;
  logic [NZONES-1:0]           heater;
  logic [NZONES-1:0]           cooler;
  logic [NZONES-1:0]           fault;
  logic [NZONES*LW-1:0]        level_out;

  // The master side drives the sensors and commands. The slave side is the controller.
  modport master (
    output enable, sensors, fault_clr,
    input  heater, cooler, fault, level_out
  );

  modport slave (
    input  enable, sensors, fault_clr,
    output heater, cooler, fault, level_out
  );
endinterface

// File: rtl/estufa_multizona.sv
// Multizone greenhouse heater/cooler controller. It uses hysteresis, a minimum on-time,
// and a latched fault that is raised after a run of malformed thermometer codes.
// Latency: an input change reaches heater/cooler/fault/level_out after one clk_2 edge.
// Backpressure: none. Sensors are sampled every cycle, and the outputs are plain levels.
// Ports:
//   clk_2   : system clock
//   reset_n : asynchronous active-low reset. It clears every zone to IDLE.
//   bus     : slave side of estufa_multizona_if.
//             Inputs are enable, sensors and fault_clr.
//             Outputs are heater, cooler, fault and level_out.
module estufa_multizona #(
  parameter int NZONES       = 2,
  parameter int NLEVELS      = 4,
  parameter int LOW_LVL      = 1,
  parameter int HEAT_OFF_LVL = 2,
  parameter int HIGH_LVL     = 3,
  parameter int COOL_OFF_LVL = 2,
  parameter int MIN_ON       = 4,
  parameter int FAULT_CYC    = 3
) (
  input  logic               clk_2,
  input  logic               reset_n,
  estufa_multizona_if.slave  bus
);

  localparam int LW = $clog2(NLEVELS + 1);
  localparam int CW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  localparam int FW = $clog2(FAULT_CYC + 1);

  localparam logic [LW-1:0] LOW_L      = LW'(LOW_LVL);
  localparam logic [LW-1:0] HEAT_OFF_L = LW'(HEAT_OFF_LVL);
  localparam logic [LW-1:0] HIGH_L     = LW'(HIGH_LVL);
  localparam logic [LW-1:0] COOL_OFF_L = LW'(COOL_OFF_LVL);
  localparam logic [CW-1:0] ON_LOAD    = CW'(MIN_ON - 1);
  localparam logic [FW-1:0] INV_MAX    = FW'(FAULT_CYC);
  localparam logic [FW-1:0] INV_LAST   = FW'(FAULT_CYC - 1);

  // Elaboration-time sanity of the threshold ordering.
  if (!(LOW_LVL <= HEAT_OFF_LVL && HEAT_OFF_LVL <= HIGH_LVL)) begin : g_bad_heat_thr
    $error("estufa_multizona: need LOW_LVL <= HEAT_OFF_LVL <= HIGH_LVL");
  end
  if (!(COOL_OFF_LVL <= HIGH_LVL)) begin : g_bad_cool_thr
    $error("estufa_multizona: need COOL_OFF_LVL <= HIGH_LVL");
  end
  if (!(HIGH_LVL <= NLEVELS)) begin : g_bad_high_thr
    $error("estufa_multizona: need HIGH_LVL <= NLEVELS");
  end
  if (MIN_ON < 1 || FAULT_CYC < 1) begin : g_bad_counts
    $error("estufa_multizona: MIN_ON and FAULT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e        state_q   [NZONES];
  state_e        state_d   [NZONES];
  logic [CW-1:0] on_cnt_q  [NZONES];
  logic [CW-1:0] on_cnt_d  [NZONES];
  logic [FW-1:0] inv_cnt_q [NZONES];
  logic [FW-1:0] inv_cnt_d [NZONES];
  logic [LW-1:0] level_q   [NZONES];
  logic [LW-1:0] level_d   [NZONES];

  logic [NLEVELS-1:0] zone_code [NZONES];
  logic [LW-1:0]      code_lvl  [NZONES];
  logic [NZONES-1:0]  code_vld;

  // Decode each zone's thermometer code.
  // A 1 directly above a 0 makes the code invalid.
  always_comb begin
    for (int z = 0; z < NZONES; z++) begin
      zone_code[z] = bus.sensors[z*NLEVELS +: NLEVELS];
      code_lvl[z]  = '0;
      code_vld[z]  = 1'b1;
      for (int k = 0; k < NLEVELS; k++) begin
        code_lvl[z] = code_lvl[z] + LW'(zone_code[z][k]);
        if (k > 0) begin
          if (zone_code[z][k] && !zone_code[z][k-1]) begin
            code_vld[z] = 1'b0;
          end
        end
      end
    end
  end

  // State register plus per-zone counters and the held level.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int z = 0; z < NZONES; z++) begin
        state_q[z]   <= ST_IDLE;
        on_cnt_q[z]  <= '0;
        inv_cnt_q[z] <= '0;
        level_q[z]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      level_q   <= level_d;
    end
  end

  // Next-state logic, one independent FSM per zone.
  // The branch order encodes the priority: fault entry, fault exit, disable, hysteresis.
  always_comb begin
    for (int z = 0; z < NZONES; z++) begin
      state_d[z]   = state_q[z];
      on_cnt_d[z]  = on_cnt_q[z];
      inv_cnt_d[z] = inv_cnt_q[z];
      level_d[z]   = level_q[z];

      if (code_vld[z]) begin
        level_d[z]   = code_lvl[z];
        inv_cnt_d[z] = '0;
      end else if (inv_cnt_q[z] != INV_MAX) begin
        inv_cnt_d[z] = inv_cnt_q[z] + 1'b1;
      end

      // The min-on timer keeps running even while the zone holds on a bad code.
      if (on_cnt_q[z] != '0) begin
        on_cnt_d[z] = on_cnt_q[z] - 1'b1;
      end

      if (!code_vld[z] && state_q[z] != ST_FAULT && inv_cnt_q[z] == INV_LAST) begin
        state_d[z] = ST_FAULT;
      end else if (state_q[z] == ST_FAULT) begin
        if (bus.fault_clr[z] && code_vld[z]) begin
          state_d[z] = ST_IDLE;
        end
      end else if (!bus.enable) begin
        state_d[z] = ST_IDLE;
      end else if (code_vld[z]) begin
        unique case (state_q[z])
          ST_IDLE: begin
            if (code_lvl[z] < LOW_L) begin
              state_d[z]  = ST_HEAT;
              on_cnt_d[z] = ON_LOAD;
            end else if (code_lvl[z] >= HIGH_L) begin
              state_d[z]  = ST_COOL;
              on_cnt_d[z] = ON_LOAD;
            end
          end
          ST_HEAT: begin
            if (on_cnt_q[z] == '0 && code_lvl[z] >= HEAT_OFF_L) begin
              state_d[z] = ST_IDLE;
            end
          end
          ST_COOL: begin
            if (on_cnt_q[z] == '0 && code_lvl[z] < COOL_OFF_L) begin
              state_d[z] = ST_IDLE;
            end
          end
          default: state_d[z] = state_q[z];
        endcase
      end
    end
  end

  // Output decode. It uses registers only, so the outputs never glitch on sensor changes.
  always_comb begin
    bus.heater    = '0;
    bus.cooler    = '0;
    bus.fault     = '0;
    bus.level_out = '0;
    for (int z = 0; z < NZONES; z++) begin
      bus.heater[z]             = (state_q[z] == ST_HEAT);
      bus.cooler[z]             = (state_q[z] == ST_COOL);
      bus.fault[z]              = (state_q[z] == ST_FAULT);
      bus.level_out[z*LW +: LW] = level_q[z];
    end
  end

endmodule

// File: tb/tb_estufa_multizona.sv
// Self-checking bench for estufa_multizona.
// It runs directed scenarios and then randomized traffic against a behavioural zone model.
// Outputs are sampled 1 time unit after each rising edge of clk_2.
module tb_estufa_multizona;

  localparam int NZ       = 2;
  localparam int NL       = 4;
  localparam int LW       = $clog2(NL + 1);
  localparam int LOW      = 1;
  localparam int HEAT_OFF = 2;
  localparam int HIGH     = 3;
  localparam int COOL_OFF = 2;
  localparam int MIN_ON   = 4;
  localparam int FCYC     = 3;

  localparam int M_IDLE  = 0;
  localparam int M_HEAT  = 1;
  localparam int M_COOL  = 2;
  localparam int M_FAULT = 3;

  logic clk_2;
  logic reset_n;

  estufa_multizona_if #(.NZONES(NZ), .NLEVELS(NL)) bus ();

  estufa_multizona #(
    .NZONES(NZ), .NLEVELS(NL), .LOW_LVL(LOW), .HEAT_OFF_LVL(HEAT_OFF),
    .HIGH_LVL(HIGH), .COOL_OFF_LVL(COOL_OFF), .MIN_ON(MIN_ON), .FAULT_CYC(FCYC)
  ) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state per zone: the mode, how many cycles the zone has been in that mode
  // (including the current one), the current streak of bad codes, and the last good level.
  int m_mode [NZ];
  int m_age  [NZ];
  int m_bad  [NZ];
  int m_lvl  [NZ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) begin
      m_mode[z] = M_IDLE;
      m_age[z]  = 0;
      m_bad[z]  = 0;
      m_lvl[z]  = 0;
    end
  endtask

  // Advance the model by one clock, using the inputs currently applied.
  task automatic model_edge();
    for (int z = 0; z < NZ; z++) begin
      logic [NL-1:0] code;
      int n;
      bit ok;
      int nm;
      code = bus.sensors[z*NL +: NL];
      n    = $countones(code);
      ok   = (int'(code) == ((1 << n) - 1));
      nm   = m_mode[z];
      if (ok) begin
        m_bad[z] = 0;
        m_lvl[z] = n;
      end else begin
        m_bad[z] = m_bad[z] + 1;
      end
      if (!ok && m_mode[z] != M_FAULT && m_bad[z] == FCYC) nm = M_FAULT;
      else if (m_mode[z] == M_FAULT) begin
        if (bus.fault_clr[z] && ok) nm = M_IDLE;
      end
      else if (!bus.enable) nm = M_IDLE;
      else if (ok) begin
        if (m_mode[z] == M_IDLE) begin
          if (n < LOW) nm = M_HEAT;
          else if (n >= HIGH) nm = M_COOL;
        end else if (m_mode[z] == M_HEAT) begin
          if (m_age[z] >= MIN_ON && n >= HEAT_OFF) nm = M_IDLE;
        end else if (m_mode[z] == M_COOL) begin
          if (m_age[z] >= MIN_ON && n < COOL_OFF) nm = M_IDLE;
        end
      end
      m_age[z]  = (nm == m_mode[z]) ? m_age[z] + 1 : 1;
      m_mode[z] = nm;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [NZ-1:0]    eh, ec, ef;
    logic [NZ*LW-1:0] el;
    eh = '0; ec = '0; ef = '0; el = '0;
    for (int z = 0; z < NZ; z++) begin
      eh[z] = (m_mode[z] == M_HEAT);
      ec[z] = (m_mode[z] == M_COOL);
      ef[z] = (m_mode[z] == M_FAULT);
      el[z*LW +: LW] = LW'(m_lvl[z]);
    end
    chk({tag, "_heater"}, 32'(bus.heater), 32'(eh));
    chk({tag, "_cooler"}, 32'(bus.cooler), 32'(ec));
    chk({tag, "_fault"},  32'(bus.fault),  32'(ef));
    chk({tag, "_level"},  32'(bus.level_out), 32'(el));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_2);
    #1;
    cyc++;
    compare_model("model");
  endtask

  // Assert the reset between edges and check that the outputs clear with no clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_heater", 32'(bus.heater), 32'd0);
    chk("rst_cooler", 32'(bus.cooler), 32'd0);
    chk("rst_fault",  32'(bus.fault),  32'd0);
    chk("rst_level",  32'(bus.level_out), 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;
  endtask

  task automatic set_zone(input int z, input logic [NL-1:0] code);
    bus.sensors[z*NL +: NL] = code;
  endtask

  function automatic logic [LW-1:0] lvl_of(input int z);
    logic [NZ*LW-1:0] v;
    v = bus.level_out;
    return v[z*LW +: LW];
  endfunction

  initial begin
    model_reset();
    reset_n       = 1'b0;
    bus.enable    = 1'b1;
    bus.fault_clr = '0;
    bus.sensors   = '0;
    set_zone(0, 4'b0110);
    set_zone(1, 4'b0011);
    #3;
    chk("init_heater", 32'(bus.heater), 32'd0);
    chk("init_cooler", 32'(bus.cooler), 32'd0);
    chk("init_fault",  32'(bus.fault),  32'd0);
    chk("init_level",  32'(bus.level_out), 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;

    // An invalid code right after reset leaves the zone idle, with no fault yet.
    step(); step();
    chk("post_rst_idle", 32'(bus.heater[0]), 32'd0);
    chk("post_rst_nofault", 32'(bus.fault[0]), 32'd0);

    // The heater stays on for the minimum on-time.
    set_zone(0, 4'b0000);
    step();
    chk("heat_on", 32'(bus.heater[0]), 32'd1);
    chk("heat_lvl0", 32'(lvl_of(0)), 32'd0);
    set_zone(0, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("heat_hold", 32'(bus.heater[0]), 32'd1);
    end
    step();
    chk("heat_off", 32'(bus.heater[0]), 32'd0);
    chk("heat_lvl2", 32'(lvl_of(0)), 32'd2);

    // Reset in the middle of a heating cycle.
    set_zone(0, 4'b0000);
    step();
    chk("pre_rst_heat", 32'(bus.heater[0]), 32'd1);
    set_zone(0, 4'b0110);
    do_reset();
    step();
    chk("rel_idle", 32'(bus.heater[0]), 32'd0);
    chk("rel_nofault", 32'(bus.fault[0]), 32'd0);

    // A cooler-to-heater reversal passes through exactly one idle cycle.
    set_zone(0, 4'b1111);
    step();
    chk("cool_on", 32'(bus.cooler[0]), 32'd1);
    set_zone(0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cool_hold", 32'(bus.cooler[0]), 32'd1);
    end
    step();
    chk("dead_cool", 32'(bus.cooler[0]), 32'd0);
    chk("dead_heat", 32'(bus.heater[0]), 32'd0);
    step();
    chk("after_dead_heat", 32'(bus.heater[0]), 32'd1);
    set_zone(0, 4'b0011);
    for (int i = 0; i < 4; i++) step();
    chk("settle_idle", 32'(bus.heater[0]), 32'd0);

    // Fault debounce: a short run of bad codes is tolerated, and the level is held.
    step();
    set_zone(0, 4'b0101);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("deb_nofault", 32'(bus.fault[0]), 32'd0);
      chk("deb_lvl_hold", 32'(lvl_of(0)), 32'd2);
    end
    set_zone(0, 4'b0001);
    step();
    chk("deb_recover", 32'(bus.fault[0]), 32'd0);
    chk("deb_lvl1", 32'(lvl_of(0)), 32'd1);
    set_zone(0, 4'b0101);
    for (int i = 0; i < 3; i++) step();
    chk("fault_set", 32'(bus.fault[0]), 32'd1);
    chk("fault_noheat", 32'(bus.heater[0]), 32'd0);
    chk("fault_nocool", 32'(bus.cooler[0]), 32'd0);
    bus.fault_clr = 2'b01;
    step();
    chk("clr_bad_ignored", 32'(bus.fault[0]), 32'd1);
    set_zone(0, 4'b0111);
    step();
    chk("clr_ok", 32'(bus.fault[0]), 32'd0);
    chk("clr_idle", 32'(bus.cooler[0]), 32'd0);
    bus.fault_clr = '0;
    set_zone(0, 4'b0011);
    for (int i = 0; i < 5; i++) step();

    // Disable: heating stops at once, and a latched fault in zone 1 survives.
    set_zone(1, 4'b0101);
    for (int i = 0; i < 3; i++) step();
    chk("z1_fault", 32'(bus.fault[1]), 32'd1);
    set_zone(0, 4'b0000);
    step();
    chk("en_heat", 32'(bus.heater[0]), 32'd1);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_heat_off", 32'(bus.heater[0]), 32'd0);
      chk("dis_fault_kept", 32'(bus.fault[1]), 32'd1);
    end
    bus.enable = 1'b1;
    bus.fault_clr = 2'b10;
    set_zone(1, 4'b0011);
    step();
    chk("z1_clr", 32'(bus.fault[1]), 32'd0);
    bus.fault_clr = '0;
    set_zone(0, 4'b0011);
    for (int i = 0; i < 5; i++) step();

    // Independent zones acting in the same cycle.
    set_zone(0, 4'b0000);
    set_zone(1, 4'b1111);
    step();
    chk("ind_heater", 32'(bus.heater), 32'b01);
    chk("ind_cooler", 32'(bus.cooler), 32'b10);
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int z = 0; z < NZ; z++) begin
        logic [NL-1:0] c;
        int n;
        int v;
        if ($urandom_range(0, 9) < 8) begin
          n = int'($urandom_range(0, NL));
          v = (1 << n) - 1;
          c = v[NL-1:0];
        end else begin
          c = NL'($urandom);
        end
        set_zone(z, c);
        bus.fault_clr[z] = ($urandom_range(0, 4) == 0);
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/estufa_multizona.md
Name: estufa_multizona

Overview:
- Parametrised sequential successor to the single-zone combinational greenhouse (estufa) controller.
- Drives heater/cooler for NZONES independent zones from thermometer-coded temperature sensors.
- Adds hysteresis, minimum actuator on-time, a heat/cool dead-time interlock, and debounced detection of inconsistent sensor codes with a latched fault.
- Instantiated inside top; sensors come from SWI, outputs go to LED/SEG.

Parameters:
- NZONES, 2, number of independent zones.
- NLEVELS, 4, thermometer bits per zone; bit k=1 means temp >= threshold k.
- LOW_LVL, 1, IDLE->HEAT when level < LOW_LVL.
- HEAT_OFF_LVL, 2, HEAT may exit when level >= HEAT_OFF_LVL.
- HIGH_LVL, 3, IDLE->COOL when level >= HIGH_LVL.
- COOL_OFF_LVL, 2, COOL may exit when level < COOL_OFF_LVL.
- MIN_ON, 4, minimum cycles spent in HEAT or COOL (>=1).
- FAULT_CYC, 3, consecutive invalid-code cycles that trigger FAULT (>=1).

Ports:
- clk_2  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  global enable; low forces non-faulted zones to IDLE
- sensors  input  NZONES*NLEVELS  zone z occupies bits [z*NLEVELS +: NLEVELS]
- fault_clr  input  NZONES  per-zone fault acknowledge
- heater  output  NZONES  heater drive per zone
- cooler  output  NZONES  cooler drive per zone
- fault  output  NZONES  latched sensor-inconsistency flag per zone
- level_out  output  NZONES*LW  last valid level per zone, LW = $clog2(NLEVELS+1)

Behaviour:
- One clock, clk_2. Reset is asynchronous and active-low on reset_n. Every register clears immediately when reset_n=0: all zones IDLE, counters 0, level_out 0, heater=cooler=fault=0. Reset mid-operation behaves identically.
- Valid code: thermometer form (no 1 above a 0); all-zeros and all-ones are valid.
- Level: number of ones in a valid code, 0..NLEVELS, unsigned LW bits. level_out is registered and updates only on valid codes; it holds its value while the code is invalid.
- Per-zone FSM states: IDLE, HEAT, COOL, FAULT. Every transition uses the inputs present before the clk_2 edge.
- Outputs decode from the state register: heater = (state==HEAT), cooler = (state==COOL), fault = (state==FAULT). Latency from input change to output is one edge.
- IDLE, valid code, enable=1:
  - level < LOW_LVL -> HEAT.
  - level >= HIGH_LVL -> COOL.
  - otherwise stay IDLE.
- Min-on counter: loaded with MIN_ON-1 on entering HEAT or COOL, then decrements to 0 and saturates there.
- HEAT -> IDLE when counter==0 and level >= HEAT_OFF_LVL. COOL -> IDLE when counter==0 and level < COOL_OFF_LVL.
- HEAT -> COOL and COOL -> HEAT are never direct; IDLE lasts at least one cycle between them. heater and cooler are never both 1.
- Invalid-code counter:
  - Increments on each cycle with an invalid code and clears on a valid code.
  - On the edge where it reaches FAULT_CYC (from any non-FAULT state) -> FAULT; this overrides MIN_ON and enable.
  - While the code is invalid and not yet faulted, the zone holds its current state (no level-based transitions).
- FAULT:
  - Both actuators off.
  - Exits to IDLE only when fault_clr=1 and the code is valid on the same cycle; the counter clears.
  - fault_clr with an invalid code is ignored. fault_clr outside FAULT has no effect.
- enable=0: HEAT/COOL -> IDLE on the next edge, ignoring MIN_ON. Zones stay in IDLE while enable=0. FAULT is unaffected, and fault detection keeps running.
- Zones are fully independent; simultaneous events in different zones resolve separately.
- Priority per zone, highest first: reset, fault entry, FAULT exit rule, enable=0, hysteresis rules.
- Elaboration parameter checks:
  - LOW_LVL <= HEAT_OFF_LVL <= HIGH_LVL
  - COOL_OFF_LVL <= HIGH_LVL
  - HIGH_LVL <= NLEVELS

Test Plan:
(defaults, enable=1 unless stated)
- Reset: drive reset_n=0 mid-HEAT -> heater/cooler/fault/level_out read 0 immediately, without waiting for an edge. Release with zone0=4'b0110 -> stays IDLE, fault=0.
- Heat with min-on, zone0:
  - 4'b0000 -> heater[0]=1 after the next edge, level_out=0.
  - Apply 4'b0011 one cycle later -> heater stays 1 for 4 cycles total, then 0. level_out=2.
- Dead time:
  - 4'b1111 -> cooler[0]=1.
  - After 1 cycle switch to 4'b0000 -> cooler stays 1 until cycle 4, then exactly one cycle with both 0, then heater[0]=1.
- Fault debounce:
  - 4'b0101 for 2 cycles, then 4'b0001 -> no fault, level_out stays at the prior valid value during the invalid cycles.
  - 4'b0101 for 3 cycles -> fault[0]=1, heater/cooler 0.
  - fault_clr=1 with 4'b0101 -> fault stays 1. fault_clr=1 with 4'b0111 -> IDLE, fault=0 next edge.
- enable: zone0 in HEAT for 1 cycle, enable=0 -> heater[0]=0 next edge. A FAULT in zone1 stays latched across enable=0.
- Independence: zone0=4'b0000, zone1=4'b1111 at the same time -> heater=2'b01, cooler=2'b10 after one edge. Neither zone's sequence is affected by the other.
